// File: rtl/vic_nested_if.sv
// Bus, interrupt-request and vector-output signals of the nested VIC.
// The width parameters must match the ones given to vic_nested.
interface vic_nested_if #(
  parameter int NUM_SRC = 32,
  parameter int ADDR_BW = 32,
  parameter int DATA_BW = 32
);
  logic [NUM_SRC-1:0] vic_intr;
  logic [ADDR_BW-1:0] bus_addr;
  logic               bus_wr;
  logic               bus_en;
  logic [DATA_BW-1:0] bus_wdata;
  logic [DATA_BW-1:0] bus_rdata;
  logic               bus_rvalid;
  logic               is_priviledge;
  logic               VICFIQEn;
  logic               VICIRQEn;
  logic               nVICFIQ;
  logic               nVICIRQ;
  logic [ADDR_BW-1:0] VICVECTADDROUT;

  modport slave (
    input  vic_intr, bus_addr, bus_wr, bus_en, bus_wdata, is_priviledge,
           VICFIQEn, VICIRQEn,
    output bus_rdata, bus_rvalid, nVICFIQ, nVICIRQ, VICVECTADDROUT
  );

  modport master (
    output vic_intr, bus_addr, bus_wr, bus_en, bus_wdata, is_priviledge,
           VICFIQEn, VICIRQEn,
    input  bus_rdata, bus_rvalid, nVICFIQ, nVICIRQ, VICVECTADDROUT
  );
endinterface

// File: rtl/vic_nested.sv
// Vectored interrupt controller with a priority-nesting stack.
// Reading VectAddr acknowledges the current winner and pushes its priority
// code; writing VectAddr ends the innermost service level (pop).
module vic_nested #(
  parameter int NUM_SRC    = 32,
  parameter int NUM_VECT   = 16,
  parameter int NEST_DEPTH = 4,
  parameter int ADDR_BW    = 32,
  parameter int DATA_BW    = 32
) (
  input logic          clk,
  input logic          rst,
  vic_nested_if.slave  bus_if
);
  localparam int CW = $clog2(NUM_VECT + 2);
  localparam int DW = 4;
  localparam logic [CW-1:0] DEF_CODE  = CW'(NUM_VECT);
  localparam logic [CW-1:0] IDLE_CODE = CW'(NUM_VECT + 1);

  logic [NUM_SRC-1:0] sync1_q, sync2_q, prev_q;
  logic [NUM_SRC-1:0] sel_q, sel_d, en_q, en_d, soft_q, soft_d;
  logic [NUM_SRC-1:0] edge_q, edge_d, pend_q, pend_d;
  logic               prot_q, prot_d;
  logic [ADDR_BW-1:0] def_vect_q, def_vect_d;
  logic [ADDR_BW-1:0] vect_addr_q [NUM_VECT];
  logic [ADDR_BW-1:0] vect_addr_d [NUM_VECT];
  logic [5:0]         vect_cntl_q [NUM_VECT];
  logic [5:0]         vect_cntl_d [NUM_VECT];
  logic [CW-1:0]      stack_q [NEST_DEPTH];
  logic [CW-1:0]      stack_d [NEST_DEPTH];
  logic [DW-1:0]      depth_q, depth_d;
  logic               ovf_q, ovf_d;
  logic [DATA_BW-1:0] rdata_q, rdata_d;
  logic               rvalid_q, rvalid_d;
  logic               nirq_q, nirq_d, nfiq_q, nfiq_d;
  logic [ADDR_BW-1:0] vout_q, vout_d;

  logic [NUM_SRC-1:0] raw, irq_st, fiq_st, rise;
  logic [31:0]        irq_ext, claimed;
  logic [CW-1:0]      ceiling, win_code;
  logic               win_valid;
  logic [ADDR_BW-1:0] win_addr;
  logic [11:0]        addr;
  logic [NUM_SRC-1:0] wd_src;
  logic               acc_ok, wr, rd, do_push, do_pop;
  logic [DATA_BW-1:0] rd_val;
  logic [NUM_SRC-1:0] en_set, en_clr, soft_set, soft_clr, pend_clr;
  logic               unused_addr_bits;

  assign addr             = bus_if.bus_addr[11:0];
  assign unused_addr_bits = ^bus_if.bus_addr[ADDR_BW-1:12];
  assign wd_src           = bus_if.bus_wdata[NUM_SRC-1:0];

  // Source status: edge-mode sources use the latched pending bit.
  always_comb begin
    rise    = sync2_q & ~prev_q;
    raw     = (edge_q & pend_q) | (~edge_q & sync2_q) | soft_q;
    irq_st  = raw & en_q & ~sel_q;
    fiq_st  = raw & en_q & sel_q;
    irq_ext = 32'(irq_st);
  end

  // Ceiling is the priority code on top of the nesting stack.
  always_comb begin
    ceiling = IDLE_CODE;
    for (int i = 0; i < NEST_DEPTH; i++)
      if (depth_q == DW'(i + 1)) ceiling = stack_q[i];
  end

  // Arbitration: lowest enabled active slot below the ceiling, else default.
  always_comb begin
    win_valid = 1'b0;
    win_code  = IDLE_CODE;
    win_addr  = def_vect_q;
    claimed   = '0;
    for (int i = NUM_VECT - 1; i >= 0; i--) begin
      if (vect_cntl_q[i][5]) begin
        claimed = claimed | (32'd1 << vect_cntl_q[i][4:0]);
        if (irq_ext[vect_cntl_q[i][4:0]] && (CW'(i) < ceiling)) begin
          win_valid = 1'b1;
          win_code  = CW'(i);
          win_addr  = vect_addr_q[i];
        end
      end
    end
    if (!win_valid && (|(irq_ext & ~claimed)) && (DEF_CODE < ceiling)) begin
      win_valid = 1'b1;
      win_code  = DEF_CODE;
      win_addr  = def_vect_q;
    end
  end

  // Register file access, stack update and output next-state.
  always_comb begin
    acc_ok   = bus_if.bus_en && !(prot_q && !bus_if.is_priviledge);
    wr       = acc_ok && bus_if.bus_wr;
    rd       = bus_if.bus_en && !bus_if.bus_wr;
    do_push  = acc_ok && !bus_if.bus_wr && (addr == 12'h030);
    do_pop   = wr && (addr == 12'h030);
    en_set   = '0; en_clr   = '0;
    soft_set = '0; soft_clr = '0;
    pend_clr = '0;
    sel_d       = sel_q;
    edge_d      = edge_q;
    prot_d      = prot_q;
    def_vect_d  = def_vect_q;
    vect_addr_d = vect_addr_q;
    vect_cntl_d = vect_cntl_q;
    stack_d     = stack_q;
    depth_d     = depth_q;
    ovf_d       = ovf_q;
    rd_val      = '0;

    if (wr) begin
      case (addr)
        12'h00C: sel_d      = wd_src;
        12'h010: en_set     = wd_src;
        12'h014: en_clr     = wd_src;
        12'h018: soft_set   = wd_src;
        12'h01C: soft_clr   = wd_src;
        12'h020: prot_d     = bus_if.bus_wdata[0];
        12'h024: edge_d     = wd_src;
        12'h028: pend_clr   = wd_src;
        12'h034: def_vect_d = ADDR_BW'(bus_if.bus_wdata);
        default: ;
      endcase
      for (int i = 0; i < NUM_VECT; i++) begin
        if (addr == 12'(256 + 4 * i)) vect_addr_d[i] = ADDR_BW'(bus_if.bus_wdata);
        if (addr == 12'(512 + 4 * i)) vect_cntl_d[i] = bus_if.bus_wdata[5:0];
      end
    end

    case (addr)
      12'h000: rd_val = DATA_BW'(irq_st);
      12'h004: rd_val = DATA_BW'(fiq_st);
      12'h008: rd_val = DATA_BW'(raw);
      12'h00C: rd_val = DATA_BW'(sel_q);
      12'h010: rd_val = DATA_BW'(en_q);
      12'h018: rd_val = DATA_BW'(soft_q);
      12'h020: rd_val = DATA_BW'(prot_q);
      12'h024: rd_val = DATA_BW'(edge_q);
      12'h030: rd_val = DATA_BW'(vout_q);
      12'h034: rd_val = DATA_BW'(def_vect_q);
      12'h038: rd_val = DATA_BW'({ovf_q, depth_q});
      default: ;
    endcase
    for (int i = 0; i < NUM_VECT; i++) begin
      if (addr == 12'(256 + 4 * i)) rd_val = DATA_BW'(vect_addr_q[i]);
      if (addr == 12'(512 + 4 * i)) rd_val = DATA_BW'(vect_cntl_q[i]);
    end

    // Clear beats set; a fresh edge beats an EdgeClr of the same bit.
    en_d   = (en_q | en_set) & ~en_clr;
    soft_d = (soft_q | soft_set) & ~soft_clr;
    pend_d = (pend_q & ~pend_clr) | (rise & edge_q);

    if (do_push && win_valid) begin
      if (depth_q == DW'(NEST_DEPTH)) begin
        ovf_d = 1'b1;
      end else begin
        for (int i = 0; i < NEST_DEPTH; i++)
          if (depth_q == DW'(i)) stack_d[i] = win_code;
        depth_d = depth_q + DW'(1);
      end
    end else if (do_pop && (depth_q != '0)) begin
      depth_d = depth_q - DW'(1);
    end

    rvalid_d = rd;
    rdata_d  = rd ? (acc_ok ? rd_val : '0) : rdata_q;
    nirq_d   = ~(bus_if.VICIRQEn & win_valid);
    nfiq_d   = ~(bus_if.VICFIQEn & (|fiq_st));
    vout_d   = win_valid ? win_addr : vout_q;
  end

  // State registers, synchroniser and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      prev_q     <= '0;
      sel_q      <= '0;
      en_q       <= '0;
      soft_q     <= '0;
      edge_q     <= '0;
      pend_q     <= '0;
      prot_q     <= 1'b0;
      def_vect_q <= '0;
      for (int i = 0; i < NUM_VECT; i++) begin
        vect_addr_q[i] <= '0;
        vect_cntl_q[i] <= '0;
      end
      for (int i = 0; i < NEST_DEPTH; i++) stack_q[i] <= '0;
      depth_q    <= '0;
      ovf_q      <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      nirq_q     <= 1'b1;
      nfiq_q     <= 1'b1;
      vout_q     <= '0;
    end else begin
      sync1_q     <= bus_if.vic_intr;
      sync2_q     <= sync1_q;
      prev_q      <= sync2_q;
      sel_q       <= sel_d;
      en_q        <= en_d;
      soft_q      <= soft_d;
      edge_q      <= edge_d;
      pend_q      <= pend_d;
      prot_q      <= prot_d;
      def_vect_q  <= def_vect_d;
      vect_addr_q <= vect_addr_d;
      vect_cntl_q <= vect_cntl_d;
      stack_q     <= stack_d;
      depth_q     <= depth_d;
      ovf_q       <= ovf_d;
      rdata_q     <= rdata_d;
      rvalid_q    <= rvalid_d;
      nirq_q      <= nirq_d;
      nfiq_q      <= nfiq_d;
      vout_q      <= vout_d;
    end
  end

  assign bus_if.bus_rdata      = rdata_q;
  assign bus_if.bus_rvalid     = rvalid_q;
  assign bus_if.nVICIRQ        = nirq_q;
  assign bus_if.nVICFIQ        = nfiq_q;
  assign bus_if.VICVECTADDROUT = vout_q;
endmodule
